// File: rtl/img_frame_streamer_if.sv
// Frame-in / row-out bus of the traffic-image streamer.
// The master modport is the streamer itself. The slave modport is the upstream source plus the row sink.
interface img_frame_streamer_if #(
    parameter int unsigned IMG_W = 32,
    parameter int unsigned IMG_H = 32
);
    localparam int unsigned FW = IMG_W * IMG_H;
    localparam int unsigned IW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned CW = $clog2(FW + 1);

    logic [FW-1:0]    frame_data;
    logic             frame_valid;
    logic             frame_ready;
    logic [IMG_W-1:0] row_data;
    logic             row_valid;
    logic             row_ready;
    logic [IW-1:0]    row_idx;
    logic             sof;
    logic             eof;
    logic [CW-1:0]    frame_ones;
    logic             ones_valid;
    logic             busy;

    modport master (
        input  frame_data, frame_valid, row_ready,
        output frame_ready, row_data, row_valid, row_idx, sof, eof,
               frame_ones, ones_valid, busy
    );

    modport slave (
        output frame_data, frame_valid, row_ready,
        input  frame_ready, row_data, row_valid, row_idx, sof, eof,
               frame_ones, ones_valid, busy
    );
endinterface

// File: rtl/img_frame_streamer.sv
// Streams one 32x32 binary frame out row by row and reports its set-pixel count at end of frame.
// The frame is captured into a shadow register that shifts up one row per accepted beat.
module img_frame_streamer #(
    parameter int unsigned IMG_W = 32,
    parameter int unsigned IMG_H = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    img_frame_streamer_if.master  bus
);
    localparam int unsigned FW = IMG_W * IMG_H;
    localparam int unsigned IW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned CW = $clog2(FW + 1);
    localparam logic [IW-1:0] LAST_ROW = IW'(IMG_H - 1);

    typedef enum logic [0:0] {IDLE, SEND} state_t;

    state_t           state, state_nxt;
    logic [FW-1:0]    shadow, shadow_nxt;
    logic [CW-1:0]    acc, acc_nxt;
    logic [IMG_W-1:0] row_data, row_data_nxt;
    logic [IW-1:0]    row_idx, row_idx_nxt;
    logic [CW-1:0]    frame_ones, frame_ones_nxt;
    logic             row_valid, row_valid_nxt;
    logic             frame_ready, frame_ready_nxt;
    logic             sof, sof_nxt;
    logic             eof, eof_nxt;
    logic             ones_valid, ones_valid_nxt;
    logic             busy, busy_nxt;
    logic             accept_c, hs_c, last_c;
    logic [CW-1:0]    sum_c;

    function automatic logic [CW-1:0] popcount(input logic [IMG_W-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < int'(IMG_W); i++) c = c + CW'(v[i]);
        return c;
    endfunction

    assign accept_c = (state == IDLE) && frame_ready && bus.frame_valid;
    assign hs_c     = (state == SEND) && row_valid && bus.row_ready;
    assign last_c   = (row_idx == LAST_ROW);
    assign sum_c    = acc + popcount(row_data);

    // State register plus all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shadow      <= '0;
            acc         <= '0;
            row_data    <= '0;
            row_idx     <= '0;
            frame_ones  <= '0;
            row_valid   <= 1'b0;
            frame_ready <= 1'b1;
            sof         <= 1'b0;
            eof         <= 1'b0;
            ones_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            acc         <= acc_nxt;
            row_data    <= row_data_nxt;
            row_idx     <= row_idx_nxt;
            frame_ones  <= frame_ones_nxt;
            row_valid   <= row_valid_nxt;
            frame_ready <= frame_ready_nxt;
            sof         <= sof_nxt;
            eof         <= eof_nxt;
            ones_valid  <= ones_valid_nxt;
            busy        <= busy_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = SEND;
            SEND:    if (hs_c && last_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and output next values; a stalled beat simply holds
    always_comb begin
        shadow_nxt     = shadow;
        acc_nxt        = acc;
        row_data_nxt   = row_data;
        row_idx_nxt    = row_idx;
        frame_ones_nxt = frame_ones;
        ones_valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    row_data_nxt = bus.frame_data[FW-1 -: IMG_W];
                    shadow_nxt   = bus.frame_data << IMG_W;
                    row_idx_nxt  = '0;
                    acc_nxt      = '0;
                end
            end
            SEND: begin
                if (hs_c) begin
                    acc_nxt = sum_c;
                    if (last_c) begin
                        frame_ones_nxt = sum_c;
                        ones_valid_nxt = 1'b1;
                        row_data_nxt   = '0;
                        row_idx_nxt    = '0;
                    end else begin
                        row_data_nxt = shadow[FW-1 -: IMG_W];
                        shadow_nxt   = shadow << IMG_W;
                        row_idx_nxt  = row_idx + IW'(1);
                    end
                end
            end
            default: ;
        endcase
        row_valid_nxt   = (state_nxt == SEND);
        frame_ready_nxt = (state_nxt == IDLE);
        busy_nxt        = (state_nxt == SEND);
        sof_nxt         = row_valid_nxt && (row_idx_nxt == '0);
        eof_nxt         = row_valid_nxt && (row_idx_nxt == LAST_ROW);
    end

    assign bus.row_data    = row_data;
    assign bus.row_valid   = row_valid;
    assign bus.row_idx     = row_idx;
    assign bus.sof         = sof;
    assign bus.eof         = eof;
    assign bus.frame_ready = frame_ready;
    assign bus.frame_ones  = frame_ones;
    assign bus.ones_valid  = ones_valid;
    assign bus.busy        = busy;
endmodule

// File: doc/img_frame_streamer.md
# img_frame_streamer

Transmit side of the traffic-image path. It accepts one complete binary image as a flat vector, using the same 32x32, 1024-bit, MSB-first layout that the TrafficSignal detectors consume and produce on `imgDataOut`. It streams the image out row by row over a valid/ready handshake to the logging/display sink. At end of frame it reports the count of set pixels, which the traffic controller uses as a lane-density figure.

## Interface
Parameters:
- IMG_W, 32, pixels per row (bits per output beat)
- IMG_H, 32, rows per frame
- Derived: FW = IMG_W*IMG_H; IW = $clog2(IMG_H); CW = $clog2(FW+1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- frame_data  in  FW  image; row 0 (top) = frame_data[FW-1 -: IMG_W], row r = frame_data[FW-1-r*IMG_W -: IMG_W]
- frame_valid  in  1  frame_data valid
- frame_ready  out  1  block can accept a frame
- row_data  out  IMG_W  current row, bit IMG_W-1 = leftmost pixel
- row_valid  out  1  row_data/row_idx/sof/eof valid
- row_ready  in  1  sink accepts row
- row_idx  out  IW  index of current row, 0..IMG_H-1
- sof  out  1  high with row 0
- eof  out  1  high with row IMG_H-1
- frame_ones  out  CW  set-pixel count of last completed frame
- ones_valid  out  1  one-cycle pulse when frame_ones updates
- busy  out  1  frame in flight (= !frame_ready)

## Operation
- Single clock; reset is asynchronous and active-low. All outputs are registered.
- States: IDLE, SEND.
- IDLE:
  - frame_ready=1, row_valid=0.
  - On frame_valid&&frame_ready: copy frame_data into an internal FW-bit shadow register, clear row counter and accumulator, go to SEND.
- SEND:
  - frame_ready=0, row_valid=1.
  - row_data = shadow row[row_idx]; sof = (row_idx==0); eof = (row_idx==IMG_H-1).
  - On row_valid&&row_ready: add popcount(row_data) to the accumulator (CW bits, never overflows; max FW).
    - If row_idx != IMG_H-1: increment row_idx.
    - Else: load frame_ones with the final sum, pulse ones_valid, go to IDLE.
- While row_valid=1 and row_ready=0, row_data, row_idx, sof and eof hold stable.
- frame_valid during SEND is ignored, because frame_ready=0. Upstream holds its frame until it is accepted.
- frame_data changes after acceptance have no effect, because the shadow copy is used.
- IMG_H=1: a single beat carries sof=eof=1.
- Reset values: frame_ready=1, row_valid=0, row_data=0, row_idx=0, sof=0, eof=0, frame_ones=0, ones_valid=0, busy=0. The state machine returns to IDLE.
- Reset asserted mid-frame: the partial frame is discarded, no ones_valid is issued, and frame_ones keeps its reset value 0.

## Timing
- Frame accepted at edge k: row 0 is presented (row_valid=1, sof=1) in the cycle after edge k.
- With row_ready held high, row r is presented in cycle k+1+r. The last handshake occurs at edge k+IMG_H.
- ones_valid is high for exactly one cycle after edge k+IMG_H. In that same cycle frame_ready=1 and row_valid=0.
- Minimum frame period is IMG_H+1 cycles (one idle bubble per frame). Back-to-back frames are accepted at edges k and k+IMG_H+1.
- Each cycle with row_ready low while row_valid is high adds exactly one cycle of latency.
- frame_ones holds its value until the next ones_valid.

## Test plan
- All-zero frame, row_ready=1: 32 beats of 0x00000000 with row_idx 0..31, sof only on beat 0 and eof only on beat 31; ones_valid 33 cycles after acceptance; frame_ones=0.
- All-ones frame: 32 beats of 0xFFFFFFFF; frame_ones=1024 (11'h400).
- Checkerboard (row r = r even ? 0xAAAAAAAA : 0x55555555) with row_ready toggling 1,0,1,0: row data matches; each beat stays stable across its stall cycle; frame_ones=512; 63 beat cycles from the first row to the last handshake.
- Back-to-back: frame A (single pixel, bit FW-1) then frame B (0xFF in row 31, low byte), frame_valid held high: B accepted exactly 33 cycles after A. A yields row 0 = 0x80000000 and frame_ones=1. B yields row 31 = 0x000000FF and frame_ones=8.
- Reset mid-frame: assert rst_n=0 after the row-10 handshake. All outputs go to reset values immediately, with no ones_valid. A new all-ones frame after release streams from row 0 and reports frame_ones=1024.
- frame_valid pulsed with a different frame during SEND: the pulse is ignored and the original frame streams intact.
